alu_cmd_loader: RTL and testbench

//  Upstream command stage for the ALU top module. Consumes a byte stream (UART RX side) framed as

---
 rtl/alu_cmd_loader.sv | 168 ++++++++++++++++
 tb/tb_alu_cmd_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_loader.sv
// Byte-stream command loader for the ALU: parses HEADER,A,B,OP frames and drives
// the shared data bus with one-cycle load strobes, then a refresh pulse.
module alu_cmd_loader #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           MODE_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] HEADER     = 8'hA5,
  parameter int unsigned           TIMEOUT    = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic [DATA_WIDTH-1:0] o_data_bus,
  output logic                  o_load_A,
  output logic                  o_load_B,
  output logic                  o_load_op,
  output logic                  o_refresh,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int unsigned CNT_W   = $clog2(TIMEOUT);
  localparam int unsigned NUM_OPS = 8;
  localparam logic [5:0] LEGAL_OPS [NUM_OPS] = '{
    6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02
  };

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_OP,
    LOAD_OP,
    REFRESH
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   bus_q, bus_d;
  logic                    load_a_q, load_a_d;
  logic                    load_b_q, load_b_d;
  logic                    load_op_q, load_op_d;
  logic                    refresh_q, refresh_d;
  logic                    err_q, err_d;

  logic                    rx_accept;
  logic                    timeout_hit;
  logic                    op_upper_zero;
  logic                    op_valid;
  logic [NUM_OPS-1:0]      op_hit;

  generate
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_match
      assign op_hit[gi] = (i_rx_data[MODE_WIDTH-1:0] == MODE_WIDTH'(LEGAL_OPS[gi]));
    end
  endgenerate

  assign op_upper_zero = ((i_rx_data >> MODE_WIDTH) == '0);
  assign op_valid      = op_upper_zero && (|op_hit);

  // The byte is only refused while the op is being pushed to the ALU.
  assign o_rx_ready  = (state_q != LOAD_OP) && (state_q != REFRESH);
  assign rx_accept   = i_rx_valid && o_rx_ready;
  // The accepting cycle counts as the first of the TIMEOUT cycles, so the abort
  // pulse appears exactly TIMEOUT cycles after the last accepted byte.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 2));

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    bus_d     = bus_q;
    load_a_d  = 1'b0;
    load_b_d  = 1'b0;
    load_op_d = 1'b0;
    refresh_d = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_accept && (i_rx_data == HEADER)) begin
          state_d = GET_A;
        end
      end
      GET_A: begin
        if (rx_accept) begin
          bus_d    = i_rx_data;
          load_a_d = 1'b1;
          state_d  = GET_B;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GET_B: begin
        if (rx_accept) begin
          bus_d    = i_rx_data;
          load_b_d = 1'b1;
          state_d  = GET_OP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GET_OP: begin
        if (rx_accept) begin
          if (op_valid) begin
            bus_d     = i_rx_data;
            load_op_d = 1'b1;
            state_d   = LOAD_OP;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD_OP: begin
        refresh_d = 1'b1;
        state_d   = REFRESH;
      end
      REFRESH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bus_q     <= '0;
      load_a_q  <= 1'b0;
      load_b_q  <= 1'b0;
      load_op_q <= 1'b0;
      refresh_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_q     <= bus_d;
      load_a_q  <= load_a_d;
      load_b_q  <= load_b_d;
      load_op_q <= load_op_d;
      refresh_q <= refresh_d;
      err_q     <= err_d;
    end
  end

  assign o_data_bus = bus_q;
  assign o_load_A   = load_a_q;
  assign o_load_B   = load_b_q;
  assign o_load_op  = load_op_q;
  assign o_refresh  = refresh_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_loader.sv
// Scoreboard bench for alu_cmd_loader: a frame-level model predicts strobe events
// with their cycle numbers; a negedge monitor matches them against the DUT.
module tb_alu_cmd_loader;

  localparam int TO = 16;

  typedef struct {
    int         cyc;
    int         kind;   // 0 load_A, 1 load_B, 2 load_op, 3 refresh, 4 err
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_valid = 1'b0;
  logic       o_rx_ready;
  logic [7:0] o_data_bus;
  logic       o_load_A, o_load_B, o_load_op, o_refresh, o_busy, o_err;

  alu_cmd_loader #(
    .DATA_WIDTH(8),
    .MODE_WIDTH(6),
    .HEADER    (8'hA5),
    .TIMEOUT   (TO)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_rx_data (i_rx_data),
    .i_rx_valid(i_rx_valid),
    .o_rx_ready(o_rx_ready),
    .o_data_bus(o_data_bus),
    .o_load_A  (o_load_A),
    .o_load_B  (o_load_B),
    .o_load_op (o_load_op),
    .o_refresh (o_refresh),
    .o_busy    (o_busy),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // frame-level reference state
  int  pos = 0;          // bytes of the current frame received (0 = hunting header)
  int  hold = 0;         // cycles the loader still refuses bytes
  int  last_acc = -1000;
  bit  model_ok = 0;
  bit  prev_rst = 0;

  // expectations for the current cycle, read by the monitor
  bit  chk_en = 0;
  bit  exp_ready = 1;
  bit  exp_busy = 0;
  bit  bus_chk = 0;
  bit  drain_chk = 0;

  function automatic bit legal_op(input logic [7:0] b);
    return b inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
  endfunction

  function automatic string kname(input int k);
    case (k)
      0: return "load_A";
      1: return "load_B";
      2: return "load_op";
      3: return "refresh";
      default: return "err";
    endcase
  endfunction

  task automatic push(input int c, input int k, input logic [7:0] d);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] d, output bit acc);
    i_rst      = r;
    i_rx_valid = v;
    i_rx_data  = d;
    exp_ready  = (hold == 0);
    exp_busy   = (pos != 0) || (hold > 0);
    chk_en     = model_ok;
    bus_chk    = prev_rst;
    acc        = 1'b0;
    if (r) begin
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].cyc > cyc) sb.delete(i);
      pos = 0;
      hold = 0;
      model_ok = 1;
    end else begin
      acc = v && (hold == 0);
      if (hold > 0) hold--;
      if (acc) begin
        last_acc = cyc;
        case (pos)
          0: if (d == 8'hA5) pos = 1;
          1: begin push(cyc + 1, 0, d); pos = 2; end
          2: begin push(cyc + 1, 1, d); pos = 3; end
          default: begin
            if (legal_op(d)) begin
              push(cyc + 1, 2, d);
              push(cyc + 2, 3, d);
              hold = 2;
            end else begin
              push(cyc + 1, 4, 8'h00);
            end
            pos = 0;
          end
        endcase
      end else if (pos != 0 && cyc == last_acc + TO - 1) begin
        push(cyc + 1, 4, 8'h00);
        pos = 0;
      end
    end
    prev_rst = r;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) step(1'b0, 1'b1, d, acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'($urandom), acc);
  endtask

  task automatic do_reset(input int n);
    bit acc;
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 8'h00, acc);
  endtask

  // monitor: all comparisons live here
  always @(negedge clk) begin
    logic [4:0] got;
    logic [4:0] want;
    ev_t        e;
    if (chk_en) begin
      checks++;
      if (o_rx_ready !== exp_ready) begin
        errors++;
        $display("FAIL ready cyc %0d got %b want %b", cyc, o_rx_ready, exp_ready);
      end
      checks++;
      if (o_busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc %0d got %b want %b", cyc, o_busy, exp_busy);
      end
      if (bus_chk) begin
        checks++;
        if (o_data_bus !== 8'h00) begin
          errors++;
          $display("FAIL reset_bus cyc %0d got %02h want 00", cyc, o_data_bus);
        end
      end
      got = {o_load_A, o_load_B, o_load_op, o_refresh, o_err};
      if ($countones(got) > 1) begin
        errors++;
        $display("FAIL exclusive cyc %0d strobes %b", cyc, got);
      end
      if (got != 5'b00000) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected cyc %0d strobes %b bus %02h", cyc, got, o_data_bus);
        end else begin
          e = sb.pop_front();
          want = 5'b10000 >> e.kind;
          if (got !== want || e.cyc != cyc ||
              (e.kind != 4 && o_data_bus !== e.data)) begin
            errors++;
            $display("FAIL event cyc %0d got %b bus %02h want %s bus %02h at cyc %0d",
                     cyc, got, o_data_bus, kname(e.kind), e.data, e.cyc);
          end else begin
            $display("cyc %0d %s bus=%02h", cyc, kname(e.kind), o_data_bus);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        checks++;
        errors++;
        e = sb.pop_front();
        $display("FAIL missing cyc %0d got none want %s bus %02h", cyc, kname(e.kind), e.data);
      end
    end
    if (drain_chk) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL leftover got %0d pending events want 0", sb.size());
      end
    end
  end

  initial begin
    logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    logic [7:0] b;
    bit acc;

    // 1: basic frame
    do_reset(2);
    send_byte(8'hA5); send_byte(8'hFF); send_byte(8'h01); send_byte(8'h20);
    idle(3);
    // 2: leading junk ignored
    send_byte(8'h00); send_byte(8'h11); send_byte(8'hA5);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h22);
    idle(3);
    // 3: bad opcodes
    send_byte(8'hA5); send_byte(8'h09); send_byte(8'h48); send_byte(8'h3F);
    idle(2);
    send_byte(8'hA5); send_byte(8'h09); send_byte(8'h48); send_byte(8'h60);
    idle(2);
    // 4: timeout, then a normal frame
    send_byte(8'hA5); send_byte(8'h05);
    idle(TO + 4);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h24);
    idle(3);
    // 5: next header offered during LOAD_OP/REFRESH; A=A5 as ordinary data
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h26);
    send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h04); send_byte(8'h27);
    idle(3);
    // 6: reset one cycle after B accepted
    send_byte(8'hA5); send_byte(8'h09); send_byte(8'h0B);
    step(1'b1, 1'b0, 8'h00, acc);
    idle(3);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h20); send_byte(8'h27);
    idle(3);

    // randomized frames
    for (int n = 0; n < 80; n++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_byte(b);
      end
      send_byte(8'hA5);
      for (int f = 0; f < 3; f++) begin
        if ($urandom_range(0, 11) == 0) idle(TO + $urandom_range(0, 2));
        else if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 29) == 0) begin
          step(1'b1, 1'b0, 8'h00, acc);
        end
        if (f < 2) begin
          send_byte(8'($urandom));
        end else if ($urandom_range(0, 9) < 7) begin
          send_byte(ops[$urandom_range(0, 7)]);
        end else begin
          send_byte(8'($urandom));
        end
      end
    end
    // a byte landing on the last allowed cycle still counts
    send_byte(8'hA5);
    idle(TO - 2);
    send_byte(8'h77); send_byte(8'h88); send_byte(8'h25);
    idle(TO + 3);

    drain_chk = 1'b1;
    step(1'b0, 1'b0, 8'h00, acc);
    drain_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
